// File: rtl/fifo_pkg.sv
// Shared sizing helpers and threshold limits for the synchronous FIFO family.
package fifo_pkg;

  localparam int AF_LEVEL_MIN = 1;
  localparam int AE_LEVEL_MIN = 0;

  function automatic int fifo_depth(input int addr_width);
    return 1 << addr_width;
  endfunction

  // One extra pointer bit separates the full and empty cases when the low bits match.
  function automatic int ptr_width(input int addr_width);
    return addr_width + 1;
  endfunction

  function automatic int cnt_width(input int addr_width);
    return addr_width + 1;
  endfunction

endpackage

// File: rtl/fifo_mem_2p.sv
// Two-port storage array: synchronous write, asynchronous read for FWFT output.
module fifo_mem_2p
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 3
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] w_addr,
  input  logic [ADDR_WIDTH-1:0] r_addr,
  input  logic [DATA_WIDTH-1:0] d,
  output logic [DATA_WIDTH-1:0] q
);

  localparam int DEPTH = fifo_depth(ADDR_WIDTH);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[w_addr] <= d;
  end

  assign q = mem[r_addr];

endmodule

// File: rtl/fifo_sync_param.sv
// Parametrised single-clock FWFT FIFO with fill count, threshold flags and sticky error flags.
module fifo_sync_param
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 3,
  parameter int AF_LEVEL   = 6,
  parameter int AE_LEVEL   = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_en,
  input  logic                  clr_err,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  overflow,
  output logic                  underflow
);

  localparam int DEPTH = fifo_depth(ADDR_WIDTH);
  localparam int PW    = ptr_width(ADDR_WIDTH);
  localparam int CW    = cnt_width(ADDR_WIDTH);

  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] AF_THR  = CW'(AF_LEVEL);
  localparam logic [CW-1:0] AE_THR  = CW'(AE_LEVEL);

  if (AF_LEVEL < AF_LEVEL_MIN || AF_LEVEL > DEPTH) begin : g_af_range
    $error("fifo_sync_param: AF_LEVEL out of range 1..DEPTH");
  end
  if (AE_LEVEL < AE_LEVEL_MIN || AE_LEVEL > DEPTH - 1) begin : g_ae_range
    $error("fifo_sync_param: AE_LEVEL out of range 0..DEPTH-1");
  end

  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count_next;
  logic          wr_ok, rd_ok;

  // A write at full is only taken when the head is popped in the same cycle.
  assign wr_ok = wr_en & (~full | rd_en);
  assign rd_ok = rd_en & ~empty;

  always_comb begin
    count_next = count;
    unique case ({wr_ok, rd_ok})
      2'b10:   count_next = count + 1'b1;
      2'b01:   count_next = count - 1'b1;
      default: count_next = count;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      empty        <= 1'b1;
      full         <= 1'b0;
      almost_empty <= 1'b1;
      almost_full  <= 1'b0;
      overflow     <= 1'b0;
      underflow    <= 1'b0;
    end else begin
      if (wr_ok) wr_ptr <= wr_ptr + 1'b1;
      if (rd_ok) rd_ptr <= rd_ptr + 1'b1;
      count        <= count_next;
      empty        <= (count_next == '0);
      full         <= (count_next == DEPTH_C);
      almost_empty <= (count_next <= AE_THR);
      almost_full  <= (count_next >= AF_THR);
      // A fresh error outranks a clear arriving in the same cycle.
      if (wr_en & full & ~rd_en) overflow <= 1'b1;
      else if (clr_err)          overflow <= 1'b0;
      if (rd_en & empty)         underflow <= 1'b1;
      else if (clr_err)          underflow <= 1'b0;
    end
  end

  fifo_mem_2p #(
    .DATA_WIDTH(DATA_WIDTH),
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_mem (
    .clk   (clk),
    .we    (wr_ok & ~reset),
    .w_addr(wr_ptr[ADDR_WIDTH-1:0]),
    .r_addr(rd_ptr[ADDR_WIDTH-1:0]),
    .d     (wr_data),
    .q     (rd_data)
  );

endmodule

// File: tb/tb_fifo_sync_param.sv
// Self-checking bench for fifo_sync_param against a queue-based reference model.
module tb_fifo_sync_param;

  localparam int DW    = 8;
  localparam int AW    = 3;
  localparam int DEPTH = 8;
  localparam int AFL   = 6;
  localparam int AEL   = 2;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          wr_en = 1'b0;
  logic [DW-1:0] wr_data = '0;
  logic          rd_en = 1'b0;
  logic          clr_err = 1'b0;
  logic [DW-1:0] rd_data;
  logic          full, empty, almost_full, almost_empty, overflow, underflow;
  logic [AW:0]   count;

  int n_tests = 0;
  int n_fail  = 0;

  logic [DW-1:0] mq[$];
  bit            m_ov = 0, m_uf = 0;

  fifo_sync_param #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .AF_LEVEL(AFL), .AE_LEVEL(AEL)
  ) dut (
    .clk(clk), .reset(reset), .wr_en(wr_en), .wr_data(wr_data), .rd_en(rd_en),
    .clr_err(clr_err), .rd_data(rd_data), .full(full), .empty(empty),
    .almost_full(almost_full), .almost_empty(almost_empty), .count(count),
    .overflow(overflow), .underflow(underflow)
  );

  always #5 clk = ~clk;

  // Drive one clock of stimulus, advance the model by the FIFO rules, settle 1ns past the edge.
  task automatic cycle(input bit w, input logic [DW-1:0] d, input bit r, input bit c);
    bit was_full, was_empty;
    was_full  = (mq.size() == DEPTH);
    was_empty = (mq.size() == 0);
    wr_en = w; wr_data = d; rd_en = r; clr_err = c;
    if (w && was_full && !r) m_ov = 1;
    else if (c)              m_ov = 0;
    if (r && was_empty)      m_uf = 1;
    else if (c)              m_uf = 0;
    if (r && !was_empty) void'(mq.pop_front());
    if (w && (!was_full || r)) mq.push_back(d);
    @(posedge clk);
    #1;
    wr_en = 0; rd_en = 0; clr_err = 0;
  endtask

  task automatic test_reset();
    @(posedge clk); #1;
    n_tests++;
    if (count !== 0 || empty !== 1 || full !== 0 || almost_empty !== 1 || almost_full !== 0) begin
      n_fail++; $display("FAIL reset_init: count=%0d empty=%b full=%b ae=%b af=%b, want 0 1 0 1 0",
                         count, empty, full, almost_empty, almost_full);
    end
    reset = 0;
    cycle(0, 8'h00, 1, 0);
    n_tests++;
    if (underflow !== 1) begin n_fail++; $display("FAIL reset_pre_uf: underflow=%b want 1", underflow); end
    for (int i = 0; i < 3; i++) cycle(1, 8'(8'h10 + i), 0, 0);
    n_tests++;
    if (count !== 3) begin n_fail++; $display("FAIL reset_pre_count: count=%0d want 3", count); end
    #2 reset = 1;
    #1;
    n_tests++;
    if (count !== 0 || empty !== 1 || almost_empty !== 1 || full !== 0 || overflow !== 0 || underflow !== 0) begin
      n_fail++; $display("FAIL reset_mid: count=%0d empty=%b ae=%b full=%b ov=%b uf=%b, want 0 1 1 0 0 0",
                         count, empty, almost_empty, full, overflow, underflow);
    end
    mq.delete(); m_ov = 0; m_uf = 0;
    @(posedge clk); #1;
    reset = 0;
  endtask

  task automatic test_fill();
    for (int i = 1; i <= 8; i++) begin
      cycle(1, 8'(i), 0, 0);
      n_tests++;
      if (count !== 4'(i) || almost_full !== (i >= AFL) || full !== (i == DEPTH) ||
          empty !== 0 || rd_data !== 8'h01) begin
        n_fail++; $display("FAIL fill_%0d: count=%0d af=%b full=%b empty=%b rd=%h, want %0d %b %b 0 01",
                           i, count, almost_full, full, empty, rd_data, i, i >= AFL, i == DEPTH);
      end
    end
  endtask

  task automatic test_overflow();
    cycle(1, 8'hAA, 0, 0);
    n_tests++;
    if (overflow !== 1 || count !== 8 || rd_data !== 8'h01) begin
      n_fail++; $display("FAIL overflow_set: ov=%b count=%0d rd=%h, want 1 8 01", overflow, count, rd_data);
    end
    cycle(0, 8'h00, 0, 0);
    n_tests++;
    if (overflow !== 1) begin n_fail++; $display("FAIL overflow_sticky: ov=%b want 1", overflow); end
    cycle(0, 8'h00, 0, 1);
    n_tests++;
    if (overflow !== 0 || count !== 8) begin
      n_fail++; $display("FAIL overflow_clr: ov=%b count=%0d, want 0 8", overflow, count);
    end
  endtask

  task automatic test_simul_full();
    logic [DW-1:0] exp_seq [8];
    exp_seq = '{8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08, 8'h55};
    cycle(1, 8'h55, 1, 0);
    n_tests++;
    if (count !== 8 || full !== 1 || rd_data !== 8'h02 || overflow !== 0) begin
      n_fail++; $display("FAIL simul_full: count=%0d full=%b rd=%h ov=%b, want 8 1 02 0",
                         count, full, rd_data, overflow);
    end
    for (int i = 0; i < 8; i++) begin
      n_tests++;
      if (rd_data !== exp_seq[i]) begin
        n_fail++; $display("FAIL drain_%0d: rd=%h want %h", i, rd_data, exp_seq[i]);
      end
      cycle(0, 8'h00, 1, 0);
    end
    n_tests++;
    if (empty !== 1 || count !== 0 || underflow !== 0) begin
      n_fail++; $display("FAIL drain_end: empty=%b count=%0d uf=%b, want 1 0 0", empty, count, underflow);
    end
  endtask

  task automatic test_underflow();
    cycle(1, 8'h33, 1, 0);
    n_tests++;
    if (underflow !== 1 || count !== 1 || rd_data !== 8'h33 || empty !== 0) begin
      n_fail++; $display("FAIL underflow: uf=%b count=%0d rd=%h empty=%b, want 1 1 33 0",
                         underflow, count, rd_data, empty);
    end
    cycle(0, 8'h00, 1, 1);
    n_tests++;
    if (underflow !== 0 || count !== 0) begin
      n_fail++; $display("FAIL underflow_clr: uf=%b count=%0d, want 0 0", underflow, count);
    end
    cycle(0, 8'h00, 1, 1);
    n_tests++;
    if (underflow !== 1) begin
      n_fail++; $display("FAIL underflow_set_wins: uf=%b want 1", underflow);
    end
    cycle(0, 8'h00, 0, 1);
  endtask

  task automatic test_wrap();
    for (int k = 0; k < 20; k++) begin
      cycle(1, 8'(8'hC0 + k), 0, 0);
      n_tests++;
      if (rd_data !== 8'(8'hC0 + k) || count !== 1 || almost_empty !== 1) begin
        n_fail++; $display("FAIL wrap_w%0d: rd=%h count=%0d ae=%b, want %h 1 1",
                           k, rd_data, count, almost_empty, 8'(8'hC0 + k));
      end
      cycle(0, 8'h00, 1, 0);
      n_tests++;
      if (count !== 0 || empty !== 1 || almost_empty !== 1) begin
        n_fail++; $display("FAIL wrap_r%0d: count=%0d empty=%b ae=%b, want 0 1 1",
                           k, count, empty, almost_empty);
      end
    end
  endtask

  task automatic test_random();
    bit w, r, c;
    int n;
    for (int t = 0; t < 400; t++) begin
      w = ($urandom_range(0, 99) < 55);
      r = ($urandom_range(0, 99) < 45);
      c = ($urandom_range(0, 99) < 8);
      cycle(w, 8'($urandom), r, c);
      n = mq.size();
      n_tests++;
      if (count !== 4'(n) || empty !== (n == 0) || full !== (n == DEPTH) ||
          almost_full !== (n >= AFL) || almost_empty !== (n <= AEL) ||
          overflow !== m_ov || underflow !== m_uf) begin
        n_fail++;
        $display("FAIL rand_%0d: count=%0d e=%b f=%b af=%b ae=%b ov=%b uf=%b, want %0d %b %b %b %b %b %b",
                 t, count, empty, full, almost_full, almost_empty, overflow, underflow,
                 n, n == 0, n == DEPTH, n >= AFL, n <= AEL, m_ov, m_uf);
      end
      if (n != 0) begin
        n_tests++;
        if (rd_data !== mq[0]) begin
          n_fail++; $display("FAIL rand_data_%0d: rd=%h want %h", t, rd_data, mq[0]);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_fill();
    test_overflow();
    test_simul_full();
    test_underflow();
    test_wrap();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
